c8_count_sequencer: RTL and testbench

- Sequential controller for the 8-bit load/count slice used by the c8 datapath (mux-select load path plus ripple-increment path with carry-out).
- Arbitrates two load requesters (A, B) onto the single load path, then steps the counter to a terminal value and reports completion.
- Drives the slice's load-select, count-enable and carry-in controls.
- Sits between the two control agents and the combinational slice; owns the only architectural copy of the count value.

---
 rtl/c8_count_sequencer_pkg.sv | 33 +++
 rtl/c8_rr_arb2.sv | 31 +++
 rtl/c8_count_sequencer.sv | 119 +++++++++++
 tb/tb_c8_count_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/c8_count_sequencer_pkg.sv
// Shared types and constants for the c8 load/count sequencer and its arbiter.
// The optional C8_COUNT_SEQ_AUTO_RELOAD_EN feature is handled in the top module.
package c8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int              DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_LIMIT = 8'hFF;

  // Round-robin choice between two requesters: on contention the one that
  // did not win last time goes first.
  function automatic logic rr_pick(input logic req_a, input logic req_b,
                                   input logic last_grant);
    logic pick;
    if (req_a && req_b) begin
      pick = ~last_grant;
    end else if (req_a) begin
      pick = REQ_A;
    end else begin
      pick = REQ_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/c8_rr_arb2.sv
// Two-input round-robin arbiter; remembers the last committed grant so that
// contending requesters alternate.
module c8_rr_arb2
  import c8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic commit,
  input  logic commit_id,
  output logic any_req,
  output logic winner
);

  logic last_grant;

  assign any_req = req_a | req_b;
  assign winner  = rr_pick(req_a, req_b, last_grant);

  // History only moves when a grant is actually acknowledged, so an aborted
  // load does not cost that requester its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_B;
    end else if (commit) begin
      last_grant <= commit_id;
    end
  end

endmodule

// File: rtl/c8_count_sequencer.sv
// Load/count sequencer for the c8 slice: arbitrates A/B loads, steps to LIMIT.
// Optional macro C8_COUNT_SEQ_AUTO_RELOAD_EN: reload last loaded value at LIMIT.
module c8_count_sequencer
  import c8_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] LIMIT = DEF_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             step,
  input  logic             abort,
  output logic             ack_a,
  output logic             ack_b,
  output logic             load_sel,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_q,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic             any_req;
  logic             winner;
  logic             live;
  logic             at_limit;
  logic             commit;
  logic [WIDTH-1:0] load_value;
`ifdef C8_COUNT_SEQ_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  c8_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .commit    (commit),
    .commit_id (load_sel),
    .any_req   (any_req),
    .winner    (winner)
  );

  // Acks and carry are combinational pulses; abort or reset suppress them.
  assign live       = ~rst & ~abort;
  assign commit     = (state == LOAD) & live;
  assign ack_a      = commit & (load_sel == REQ_A);
  assign ack_b      = commit & (load_sel == REQ_B);
  assign cnt_en     = step & (state == COUNT);
  assign at_limit   = (cnt_q == LIMIT);
  assign carry      = cnt_en & live & at_limit;
  assign load_value = (load_sel == REQ_B) ? data_b : data_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt_q    <= '0;
      load_sel <= REQ_A;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef C8_COUNT_SEQ_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (any_req) begin
            load_sel <= winner;
            state    <= LOAD;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt_q <= load_value;
`ifdef C8_COUNT_SEQ_AUTO_RELOAD_EN
            reload_q <= load_value;
`endif
            state <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step) begin
            if (at_limit) begin
`ifdef C8_COUNT_SEQ_AUTO_RELOAD_EN
              // Free-running mode: restart from the loaded value, never finish.
              cnt_q <= reload_q;
`else
              cnt_q <= cnt_q + 1'b1;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c8_count_sequencer.sv
// Scoreboard bench for c8_count_sequencer: a behavioural model queues the
// expected outputs of every cycle and a monitor compares them to the DUT.
module tb_c8_count_sequencer;

  localparam int         W   = 8;
  localparam logic [7:0] LIM = 8'hFF;

  logic         clk = 1'b0;
  logic         rst, req_a, req_b, step, abort;
  logic [W-1:0] data_a, data_b;
  logic         ack_a, ack_b, load_sel, cnt_en, carry, busy, done;
  logic [W-1:0] cnt_q;

  typedef struct {
    bit         chk;
    logic       ack_a;
    logic       ack_b;
    logic       load_sel;
    logic [7:0] cnt;
    logic       carry;
    logic       busy;
    logic       done;
    logic       cnt_en;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Model state: phase 0 idle, 1 loading, 2 counting, 3 finishing.
  int         m_phase = 0;
  bit         m_sel   = 1'b0;
  bit         m_last  = 1'b1;
  logic [7:0] m_cnt   = 8'h00;
  logic [7:0] m_loaded = 8'h00;
  bit         m_seen_reset = 1'b0;

  c8_count_sequencer #(.WIDTH(W), .LIMIT(LIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .data_a   (data_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .step     (step),
    .abort    (abort),
    .ack_a    (ack_a),
    .ack_b    (ack_b),
    .load_sel (load_sel),
    .cnt_en   (cnt_en),
    .cnt_q    (cnt_q),
    .carry    (carry),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act,
                              input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit ra, input logic [7:0] da,
                                input bit rb, input logic [7:0] db,
                                input bit s, input bit ab);
    rst    = r;
    req_a  = ra;
    data_a = da;
    req_b  = rb;
    data_b = db;
    step   = s;
    abort  = ab;
    @(posedge clk);
    #1;
  endtask

  // Reference model: predict this cycle's outputs, then advance.
  always @(negedge clk) begin
    exp_t e;
    bit   working;
    working    = !rst && !abort;
    e.chk      = m_seen_reset;
    e.ack_a    = (m_phase == 1) && working && (m_sel == 1'b0);
    e.ack_b    = (m_phase == 1) && working && (m_sel == 1'b1);
    e.load_sel = m_sel;
    e.cnt      = m_cnt;
    e.cnt_en   = (m_phase == 2) && step;
    e.carry    = (m_phase == 2) && step && working && (m_cnt == LIM);
    e.busy     = (m_phase == 1) || (m_phase == 2);
    e.done     = (m_phase == 3);
    exp_q.push_back(e);

    if (rst) begin
      m_phase = 0;
      m_sel   = 1'b0;
      m_last  = 1'b1;
      m_cnt   = 8'h00;
      m_loaded = 8'h00;
      m_seen_reset = 1'b1;
    end else if (m_phase == 0) begin
      if (req_a || req_b) begin
        if (req_a && req_b) m_sel = !m_last;
        else                m_sel = req_b;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (abort) m_phase = 0;
      else begin
        m_cnt    = m_sel ? data_b : data_a;
        m_loaded = m_cnt;
        m_last   = m_sel;
        m_phase  = 2;
      end
    end else if (m_phase == 2) begin
      if (abort) m_phase = 0;
      else if (step) begin
        if (m_cnt == LIM) begin
`ifdef C8_COUNT_SEQ_AUTO_RELOAD_EN
          m_cnt = m_loaded;
`else
          m_cnt   = 8'((int'(m_cnt) + 1) % 256);
          m_phase = 3;
`endif
        end else begin
          m_cnt = 8'((int'(m_cnt) + 1) % 256);
        end
      end
    end else begin
      m_phase = 0;
    end
  end

  // Monitor: pop one expectation per cycle and compare with what the DUT shows.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard at %0t: got empty queue expected an entry", $time);
    end else begin
      e = exp_q.pop_front();
      if (e.chk) begin
        check_output("ack_a", {7'd0, ack_a}, {7'd0, e.ack_a});
        check_output("ack_b", {7'd0, ack_b}, {7'd0, e.ack_b});
        check_output("load_sel", {7'd0, load_sel}, {7'd0, e.load_sel});
        check_output("cnt_q", cnt_q, e.cnt);
        check_output("cnt_en", {7'd0, cnt_en}, {7'd0, e.cnt_en});
        check_output("carry", {7'd0, carry}, {7'd0, e.carry});
        check_output("busy", {7'd0, busy}, {7'd0, e.busy});
        check_output("done", {7'd0, done}, {7'd0, e.done});
      end
    end
  end

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; step = 1'b0; abort = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    apply_stimulus(1, 0, 8'h00, 0, 8'h00, 0, 0);
    apply_stimulus(1, 0, 8'h00, 0, 8'h00, 0, 0);

    $display("[TB] single A load at FC, count through the terminal value");
    apply_stimulus(0, 1, 8'hFC, 0, 8'h00, 0, 0);
    apply_stimulus(0, 0, 8'hFC, 0, 8'h00, 0, 0);
    repeat (4) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);
    repeat (3) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 0);

    $display("[TB] contending requesters held high");
    repeat (30) apply_stimulus(0, 1, 8'hFD, 1, 8'hFE, 1, 0);
    repeat (3) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 0);

    $display("[TB] B load with step held low");
    apply_stimulus(0, 0, 8'h00, 1, 8'h10, 0, 0);
    apply_stimulus(0, 0, 8'h00, 0, 8'h10, 0, 0);
    repeat (20) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 0);
    apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 1);
    apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 0);

    $display("[TB] abort while counting at 42");
    apply_stimulus(0, 1, 8'h40, 0, 8'h00, 0, 0);
    apply_stimulus(0, 0, 8'h40, 0, 8'h00, 0, 0);
    repeat (2) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);
    apply_stimulus(0, 0, 8'h00, 0, 8'h00, 1, 1);
    repeat (2) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 0);

    $display("[TB] reset while counting at 80, then contention");
    apply_stimulus(0, 0, 8'h00, 1, 8'h7E, 0, 0);
    apply_stimulus(0, 0, 8'h00, 0, 8'h7E, 0, 0);
    repeat (2) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 1, 0);
    apply_stimulus(1, 1, 8'h11, 1, 8'h22, 1, 0);
    apply_stimulus(0, 1, 8'h11, 1, 8'h22, 0, 0);
    apply_stimulus(0, 0, 8'h11, 0, 8'h22, 0, 0);
    repeat (3) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] da, db;
      da = ($urandom % 2 == 0) ? (8'hF0 | 8'($urandom % 16)) : 8'($urandom);
      db = ($urandom % 2 == 0) ? (8'hF0 | 8'($urandom % 16)) : 8'($urandom);
      apply_stimulus(($urandom % 500) == 0, ($urandom % 4) == 0, da,
                     ($urandom % 4) == 0, db, ($urandom % 10) < 7,
                     ($urandom % 150) == 0);
    end
    repeat (4) apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, 0);
    @(negedge clk);
    #4;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
